// File: rtl/cnn_frame_sequencer_pkg.sv
// Shared definitions for the Braille CNN frame sequencer: FSM state
// encodings, classifier ASCII/LED codes and default frame/timeout sizes.
// The SEND_NL state exists only when CNN_SEQ_NEWLINE_EN is defined.
package cnn_frame_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FEED    = 3'd1,
    ST_WAIT    = 3'd2,
`ifdef CNN_SEQ_NEWLINE_EN
    ST_SEND    = 3'd3,
    ST_SEND_NL = 3'd4
`else
    ST_SEND    = 3'd3
`endif
  } state_t;

  localparam logic [7:0] ASCII_A  = 8'h61;
  localparam logic [7:0] ASCII_B  = 8'h62;
  localparam logic [7:0] ASCII_C  = 8'h63;
  localparam logic [7:0] ASCII_NL = 8'h0A;

  localparam logic [2:0] LED_A = 3'b100;
  localparam logic [2:0] LED_B = 3'b010;
  localparam logic [2:0] LED_C = 3'b001;

  localparam int DEF_PIX_NUM = 784;
  localparam int DEF_TIMEOUT = 4095;

endpackage

// File: rtl/cnn_frame_sequencer_timeout.sv
// Watchdog counter for the sequencer's WAIT state: a loadable up-counter
// with synchronous clear and enable. done is high on the enabled cycle
// whose increment makes the count reach LIMIT, so the caller can act on
// the same edge the limit is reached.
module cnn_seq_timeout
  import cnn_frame_sequencer_pkg::*;
#(
  parameter int LIMIT = DEF_TIMEOUT,
  parameter int CNT_W = $clog2(LIMIT + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             done
);

  logic [CNT_W-1:0] count;

  // Count register: clear has priority over load, load over increment.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign done = en && (count == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/cnn_frame_sequencer.sv
// Braille CNN frame sequencer: on start, streams PIX_NUM pixels from the
// frame buffer into stage 1, waits (with watchdog) for the classifier
// result strobe, then hands the result byte to the UART over valid/ready.
// Optional macro CNN_SEQ_NEWLINE_EN appends a 0x0A byte after each result.
module cnn_frame_sequencer
  import cnn_frame_sequencer_pkg::*;
#(
  parameter int PIX_NUM = DEF_PIX_NUM,
  parameter int ADDR_W  = 10,
  parameter int PIX_BW  = 8,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_rd_en,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic [PIX_BW-1:0] i_rd_data,
  output logic              o_pix_valid,
  output logic [PIX_BW-1:0] o_pix,
  input  logic              i_cls_valid,
  input  logic [7:0]        i_alpha,
  input  logic [2:0]        i_led,
  output logic              o_tx_valid,
  output logic [7:0]        o_tx_data,
  input  logic              i_tx_ready,
  output logic [2:0]        o_led,
  output logic              o_err
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIX_NUM - 1);

  state_t state;
  state_t next_state;

  logic              tmo_done;
  logic              tmo_clear;
  logic              tmo_en;

  logic              busy_d;
  logic              rd_en_d;
  logic [ADDR_W-1:0] rd_addr_d;
  logic              tx_valid_d;
  logic [7:0]        tx_data_d;
  logic [2:0]        led_d;
  logic              err_d;

  // The watchdog runs only while waiting and is cleared in every other
  // state, which clears it on WAIT entry.
  assign tmo_clear = (state != ST_WAIT);
  assign tmo_en    = (state == ST_WAIT);

  cnn_seq_timeout #(
    .LIMIT (TIMEOUT)
  ) u_timeout (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (tmo_clear),
    .load     (1'b0),
    .load_val ('0),
    .en       (tmo_en),
    .done     (tmo_done)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; a result in the timeout cycle takes priority.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (i_start) next_state = ST_FEED;
      ST_FEED: if (o_rd_addr == LAST_ADDR) next_state = ST_WAIT;
      ST_WAIT: begin
        if (i_cls_valid) begin
          next_state = ST_SEND;
        end else if (tmo_done) begin
          next_state = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (i_tx_ready) begin
`ifdef CNN_SEQ_NEWLINE_EN
          next_state = ST_SEND_NL;
`else
          next_state = ST_IDLE;
`endif
        end
      end
`ifdef CNN_SEQ_NEWLINE_EN
      ST_SEND_NL: if (i_tx_ready) next_state = ST_IDLE;
`endif
      default: next_state = ST_IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs, derived from the
  // upcoming state so each output changes on the same edge as the state.
  always_comb begin
    busy_d     = (next_state != ST_IDLE);
    rd_en_d    = (next_state == ST_FEED);
    rd_addr_d  = '0;
    tx_valid_d = (next_state == ST_SEND);
    tx_data_d  = o_tx_data;
    led_d      = o_led;
    err_d      = 1'b0;
    if ((state == ST_FEED) && (next_state == ST_FEED)) begin
      rd_addr_d = o_rd_addr + ADDR_W'(1);
    end
    if ((state == ST_WAIT) && i_cls_valid) begin
      tx_data_d = i_alpha;
      led_d     = i_led;
    end
    if ((state == ST_WAIT) && !i_cls_valid && tmo_done) begin
      err_d = 1'b1;
    end
`ifdef CNN_SEQ_NEWLINE_EN
    if (next_state == ST_SEND_NL) begin
      tx_valid_d = 1'b1;
    end
    if ((state == ST_SEND) && i_tx_ready) begin
      tx_data_d = ASCII_NL;
    end
`endif
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      o_busy     <= 1'b0;
      o_rd_en    <= 1'b0;
      o_rd_addr  <= '0;
      o_tx_valid <= 1'b0;
      o_tx_data  <= '0;
      o_led      <= 3'b000;
      o_err      <= 1'b0;
    end else begin
      o_busy     <= busy_d;
      o_rd_en    <= rd_en_d;
      o_rd_addr  <= rd_addr_d;
      o_tx_valid <= tx_valid_d;
      o_tx_data  <= tx_data_d;
      o_led      <= led_d;
      o_err      <= err_d;
    end
  end

  // Pixel stage: frame-buffer read strobe and data delayed one cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      o_pix_valid <= 1'b0;
      o_pix       <= '0;
    end else begin
      o_pix_valid <= o_rd_en;
      o_pix       <= i_rd_data;
    end
  end

endmodule

// File: tb/tb_cnn_frame_sequencer.sv
// Scoreboard bench for cnn_frame_sequencer (PIX_NUM=784, TIMEOUT=16).
// A driver issues randomized frames and pushes expected pixels, tx bytes
// and error pulses; a negedge monitor pops and compares DUT outputs.
module tb_cnn_frame_sequencer;

  localparam int PIX_NUM = 784;
  localparam int ADDR_W  = 10;
  localparam int PIX_BW  = 8;
  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              i_start;
  logic              o_busy;
  logic              o_rd_en;
  logic [ADDR_W-1:0] o_rd_addr;
  logic [PIX_BW-1:0] i_rd_data;
  logic              o_pix_valid;
  logic [PIX_BW-1:0] o_pix;
  logic              i_cls_valid;
  logic [7:0]        i_alpha;
  logic [2:0]        i_led;
  logic              o_tx_valid;
  logic [7:0]        o_tx_data;
  logic              i_tx_ready;
  logic [2:0]        o_led;
  logic              o_err;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] exp_pix[$];
  logic [7:0] exp_tx[$];
  int         exp_err_n = 0;
  logic [2:0] model_led = 3'b000;

  cnn_frame_sequencer #(
    .PIX_NUM (PIX_NUM),
    .ADDR_W  (ADDR_W),
    .PIX_BW  (PIX_BW),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_start     (i_start),
    .o_busy      (o_busy),
    .o_rd_en     (o_rd_en),
    .o_rd_addr   (o_rd_addr),
    .i_rd_data   (i_rd_data),
    .o_pix_valid (o_pix_valid),
    .o_pix       (o_pix),
    .i_cls_valid (i_cls_valid),
    .i_alpha     (i_alpha),
    .i_led       (i_led),
    .o_tx_valid  (o_tx_valid),
    .o_tx_data   (o_tx_data),
    .i_tx_ready  (i_tx_ready),
    .o_led       (o_led),
    .o_err       (o_err)
  );

  always #5 clk = ~clk;

  // Frame buffer model: data = low address byte for the issued read.
  assign i_rd_data = o_rd_en ? o_rd_addr[7:0] : 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_ctl"}, {o_busy, o_rd_en, o_rd_addr, o_pix_valid, o_err}, 32'h0);
    chk({name, "_dat"}, {o_pix, o_tx_valid, o_tx_data, o_led}, 32'h0);
  endtask

  // Monitor: compares every pixel strobe, tx handshake and error pulse.
  initial begin : monitor
    logic       prev_pv;
    logic       prev_hold;
    logic [7:0] prev_data;
    logic [7:0] e;
    prev_pv = 1'b0;
    prev_hold = 1'b0;
    prev_data = 8'h00;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_pv = 1'b0;
        prev_hold = 1'b0;
      end else begin
        if (o_pix_valid) begin
          if (exp_pix.size() == 0) begin
            chk("pix_unexpected", 32'(o_pix_valid), 32'h0);
          end else begin
            e = exp_pix.pop_front();
            chk("pix_data", 32'(o_pix), 32'(e));
            chk("pix_busy", 32'(o_busy), 32'h1);
          end
        end else if (prev_pv && exp_pix.size() != 0) begin
          chk("pix_gap", 32'(o_pix_valid), 32'h1);
        end
        prev_pv = o_pix_valid;

        if (prev_hold) chk("tx_hold", {o_tx_valid, o_tx_data}, {1'b1, prev_data});
        if (o_tx_valid && i_tx_ready) begin
          if (exp_tx.size() == 0) begin
            chk("tx_unexpected", {o_tx_valid, o_tx_data}, 32'h0);
          end else begin
            e = exp_tx.pop_front();
            chk("tx_data", 32'(o_tx_data), 32'(e));
            chk("tx_led", 32'(o_led), 32'(model_led));
          end
        end
        prev_hold = o_tx_valid && !i_tx_ready;
        prev_data = o_tx_data;

        if (o_err) begin
          if (exp_err_n == 0) begin
            chk("err_unexpected", 32'(o_err), 32'h0);
          end else begin
            exp_err_n--;
            chk("err_led", 32'(o_led), 32'(model_led));
          end
        end
      end
    end
  end

  // One frame. k >= TIMEOUT means no classifier result; rst_at > 0 resets
  // the block while address rst_at is being issued.
  task automatic run_frame(input int k, input int idx, input int rdly,
                           input bit glitch, input int rst_at);
    int  j;
    bit  got_result;
    bit  done;
    logic [7:0] alpha;
    repeat (2) begin @(posedge clk); #1; end
    for (int a = 0; a < PIX_NUM; a++) exp_pix.push_back(8'(a));
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    chk("start_busy", 32'(o_busy), 32'h1);
    chk("start_rd_en", 32'(o_rd_en), 32'h1);
    chk("start_addr", 32'(o_rd_addr), 32'h0);
    chk("start_pv", 32'(o_pix_valid), 32'h0);
    for (int c = 1; c <= PIX_NUM; c++) begin
      if (rst_at > 0 && c == rst_at + 1) begin
        chk("rst_addr", 32'(o_rd_addr), 32'(rst_at));
        reset_n = 1'b0;
        @(posedge clk); #1;
        chk_all_zero("rst_mid");
        reset_n = 1'b1;
        exp_pix.delete();
        model_led = 3'b000;
        return;
      end
      if (glitch) begin
        i_start     = (c == 100);
        i_cls_valid = (c == 100);
        i_alpha     = 8'($urandom);
        i_led       = 3'($urandom);
      end
      @(posedge clk); #1;
      if (c == 1) chk("pv_first", 32'(o_pix_valid), 32'h1);
    end
    i_start = 1'b0;
    i_cls_valid = 1'b0;
    chk("wait_busy", 32'(o_busy), 32'h1);
    chk("wait_rd_en", 32'(o_rd_en), 32'h0);
    got_result = 1'b0;
    for (j = 0; j < TIMEOUT; j++) begin
      if (j == k) begin
        alpha       = 8'h61 + 8'(idx);
        i_cls_valid = 1'b1;
        i_alpha     = alpha;
        i_led       = 3'b100 >> idx;
        i_tx_ready  = 1'b0;
        model_led   = 3'b100 >> idx;
        exp_tx.push_back(alpha);
`ifdef CNN_SEQ_NEWLINE_EN
        exp_tx.push_back(8'h0A);
`endif
        @(posedge clk); #1;
        i_cls_valid = 1'b0;
        i_alpha     = 8'($urandom);
        chk("tx_valid_rise", 32'(o_tx_valid), 32'h1);
        chk("led_update", 32'(o_led), 32'(model_led));
        got_result = 1'b1;
        break;
      end
      if (j == TIMEOUT - 1) exp_err_n++;
      @(posedge clk); #1;
      if (j == 0) chk("pv_end", 32'(o_pix_valid), 32'h0);
    end
    if (!got_result) begin
      chk("err_pulse", 32'(o_err), 32'h1);
      chk("err_busy", 32'(o_busy), 32'h0);
      chk("err_no_tx", 32'(o_tx_valid), 32'h0);
      chk("err_led_kept", 32'(o_led), 32'(model_led));
    end else begin
      repeat (rdly) begin @(posedge clk); #1; end
      i_tx_ready = 1'b1;
      done = 1'b0;
      for (int n = 0; n < 20; n++) begin
        @(posedge clk); #1;
        if (!o_busy) begin done = 1'b1; break; end
      end
      chk("send_done", 32'(done), 32'h1);
      i_tx_ready = 1'b0;
      chk("idle_tx_valid", 32'(o_tx_valid), 32'h0);
      chk("idle_led", 32'(o_led), 32'(model_led));
    end
    chk("frame_pix_left", 32'(exp_pix.size()), 32'h0);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin : driver
    reset_n     = 1'b0;
    i_start     = 1'b0;
    i_cls_valid = 1'b0;
    i_alpha     = 8'h00;
    i_led       = 3'b000;
    i_tx_ready  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    reset_n = 1'b1;

    run_frame(3, 1, 5, 1'b0, 0);             // result 'b', ready held low 5 cycles
    run_frame(TIMEOUT + 5, 0, 0, 1'b0, 0);   // timeout, LED must stay 010
    run_frame(TIMEOUT - 1, 0, 1, 1'b0, 0);   // result in the timeout cycle
    run_frame(7, 2, 2, 1'b1, 0);             // start/result glitch during FEED
    run_frame(0, 0, 0, 1'b0, 300);           // reset while issuing address 300
    run_frame(2, 0, 0, 1'b0, 0);             // restart after reset: 'a'
    for (int f = 0; f < 6; f++) begin
      run_frame($urandom_range(0, TIMEOUT + 3), $urandom_range(0, 2),
                $urandom_range(0, 4), 1'($urandom_range(0, 1)), 0);
    end

    repeat (3) begin @(posedge clk); #1; end
    chk("end_tx_left", 32'(exp_tx.size()), 32'h0);
    chk("end_err_left", 32'(exp_err_n), 32'h0);
    chk("end_idle", 32'(o_busy), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
